// File: rtl/ascon_block_packer.sv
// ascon_block_packer
//
// Packs a byte stream of associated data or plaintext into 64-bit blocks
// for the Ascon core. The first byte of a block lands in [63:56]. A block is
// presented when 8 bytes have been collected or the segment's last byte
// arrives. The block is then held until the core pulses read.
//
// With FLUSH_EMPTY=1, a segment that ends exactly on an 8-byte boundary is
// followed by one extra empty block (len 0, last 1). This gives the core the
// padding-only block that it expects.
//
// Ports:
//   clk, rst        clock and asynchronous active-high reset
//   byte_in         next stream byte
//   byte_valid      byte_in is valid this cycle
//   byte_last       byte_in is the final byte of its segment
//   byte_is_ad      1 = associated data, 0 = plaintext
//   byte_ready      packer accepts a byte this cycle
//   blk_data        packed block, unused low bytes zero
//   blk_len         valid bytes in blk_data (0..8)
//   blk_is_ad       block type, taken from the block's first byte
//   blk_last        block is the last of its segment
//   blk_valid       block outputs are stable and valid
//   read            core consumed the presented block (one-cycle pulse)

module ascon_block_packer #(
  parameter bit FLUSH_EMPTY = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  byte_in,
  input  logic        byte_valid,
  input  logic        byte_last,
  input  logic        byte_is_ad,
  output logic        byte_ready,
  output logic [63:0] blk_data,
  output logic [3:0]  blk_len,
  output logic        blk_is_ad,
  output logic        blk_last,
  output logic        blk_valid,
  input  logic        read
);

  typedef enum logic [1:0] {
    FILL  = 2'd0,
    HOLD  = 2'd1,
    EMPTY = 2'd2
  } state_t;

  state_t      state;
  state_t      state_next;
  logic [2:0]  cnt;
  logic        pending;
  logic [63:0] data_q;
  logic [3:0]  len_q;
  logic        is_ad_q;
  logic        last_q;
  logic        ready_q;
  logic        valid_q;

  logic        accept;
  logic        block_done;
  logic        full_last;
  logic [2:0]  lane;

  assign accept     = byte_valid && ready_q && (state == FILL);
  assign block_done = accept && ((cnt == 3'd7) || byte_last);
  // A segment that ends on a full block owes the core a trailing empty block.
  assign full_last  = FLUSH_EMPTY && byte_last && (cnt == 3'd7);
  assign lane       = 3'd7 - cnt;

  assign byte_ready = ready_q;
  assign blk_data   = data_q;
  assign blk_len    = len_q;
  assign blk_is_ad  = is_ad_q;
  assign blk_last   = last_q;
  assign blk_valid  = valid_q;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= FILL;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic. A read pulse seen while filling has no effect.
  always_comb begin
    state_next = state;
    case (state)
      FILL:    if (block_done) state_next = HOLD;
      HOLD:    if (read) state_next = pending ? EMPTY : FILL;
      EMPTY:   if (read) state_next = FILL;
      default: state_next = FILL;
    endcase
  end

  // Datapath and registered handshake flags.
  // ready and valid are computed from state_next, so they line up with the
  // state that the register holds after this edge. byte_ready is held at 0
  // during reset and rises on the first edge after release.
  // The data register and cnt are cleared on every entry to FILL, so the
  // unused low lanes of a short block are always zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt     <= 3'd0;
      pending <= 1'b0;
      data_q  <= 64'd0;
      len_q   <= 4'd0;
      is_ad_q <= 1'b0;
      last_q  <= 1'b0;
      ready_q <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      ready_q <= (state_next == FILL);
      valid_q <= (state_next != FILL);
      case (state)
        FILL: begin
          if (accept) begin
            data_q[{lane, 3'b000} +: 8] <= byte_in;
            if (cnt == 3'd0) begin
              is_ad_q <= byte_is_ad;
            end
            if (block_done) begin
              cnt     <= 3'd0;
              len_q   <= {1'b0, cnt} + 4'd1;
              last_q  <= byte_last && !full_last;
              pending <= full_last;
            end else begin
              cnt <= cnt + 3'd1;
            end
          end
        end
        HOLD: begin
          if (read) begin
            data_q <= 64'd0;
            len_q  <= 4'd0;
            cnt    <= 3'd0;
            last_q <= pending;
          end
        end
        EMPTY: begin
          if (read) begin
            pending <= 1'b0;
            data_q  <= 64'd0;
            len_q   <= 4'd0;
            last_q  <= 1'b0;
            cnt     <= 3'd0;
          end
        end
        default: begin
          cnt <= 3'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ascon_block_packer.sv
// tb_ascon_block_packer
//
// Directed bench for ascon_block_packer. The dut instance uses the default
// FLUSH_EMPTY=1. The nf instance uses FLUSH_EMPTY=0 and shares the byte
// data lines with dut, but it has its own valid and read lines.
// Inputs are driven and outputs are sampled on the falling clock edge.

module tb_ascon_block_packer;

  logic        clk;
  logic        rst;
  logic [7:0]  byte_in;
  logic        byte_valid;
  logic        byte_last;
  logic        byte_is_ad;
  logic        read;
  logic        byte_ready;
  logic [63:0] blk_data;
  logic [3:0]  blk_len;
  logic        blk_is_ad;
  logic        blk_last;
  logic        blk_valid;

  logic        nf_byte_valid;
  logic        nf_read;
  logic        nf_byte_ready;
  logic [63:0] nf_blk_data;
  logic [3:0]  nf_blk_len;
  logic        nf_blk_is_ad;
  logic        nf_blk_last;
  logic        nf_blk_valid;

  int checks;
  int failures;

  ascon_block_packer #(.FLUSH_EMPTY(1'b1)) dut (
    .clk(clk), .rst(rst), .byte_in(byte_in), .byte_valid(byte_valid),
    .byte_last(byte_last), .byte_is_ad(byte_is_ad), .byte_ready(byte_ready),
    .blk_data(blk_data), .blk_len(blk_len), .blk_is_ad(blk_is_ad),
    .blk_last(blk_last), .blk_valid(blk_valid), .read(read)
  );

  ascon_block_packer #(.FLUSH_EMPTY(1'b0)) nf (
    .clk(clk), .rst(rst), .byte_in(byte_in), .byte_valid(nf_byte_valid),
    .byte_last(byte_last), .byte_is_ad(byte_is_ad), .byte_ready(nf_byte_ready),
    .blk_data(nf_blk_data), .blk_len(nf_blk_len), .blk_is_ad(nf_blk_is_ad),
    .blk_last(nf_blk_last), .blk_valid(nf_blk_valid), .read(nf_read)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present one byte to instance sel (0 = dut, 1 = nf) and wait until it is
  // accepted. The task returns on the falling edge after acceptance, with
  // valid still high.
  task automatic applyStimulus(input bit sel, input logic [7:0] b,
                               input logic l, input logic ad);
    int waited;
    logic rdy;
    waited = 0;
    byte_in = b;
    byte_last = l;
    byte_is_ad = ad;
    if (sel) nf_byte_valid = 1'b1;
    else     byte_valid = 1'b1;
    rdy = sel ? nf_byte_ready : byte_ready;
    while (rdy !== 1'b1 && waited < 40) begin
      @(negedge clk);
      waited++;
      rdy = sel ? nf_byte_ready : byte_ready;
    end
    checks++;
    if (rdy !== 1'b1) begin
      failures++;
      $display("[TB] FAIL accept_timeout byte=%h ready got=%b exp=1", b, rdy);
    end
    @(negedge clk);
  endtask

  task automatic idle();
    byte_valid = 1'b0;
    nf_byte_valid = 1'b0;
    byte_last = 1'b0;
  endtask

  task automatic pulse_read();
    read = 1'b1;
    @(negedge clk);
    read = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({byte_ready, blk_valid, blk_last, blk_is_ad} !== 4'b0000 ||
        blk_data !== 64'd0 || blk_len !== 4'd0) begin
      failures++;
      $display("[TB] FAIL reset_outputs got rdy=%b val=%b last=%b ad=%b data=%h len=%0d exp all 0",
               byte_ready, blk_valid, blk_last, blk_is_ad, blk_data, blk_len);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (byte_ready !== 1'b0) begin
      failures++;
      $display("[TB] FAIL ready_before_edge got=%b exp=0", byte_ready);
    end
    @(negedge clk);
    checks++;
    if (byte_ready !== 1'b1 || blk_valid !== 1'b0) begin
      failures++;
      $display("[TB] FAIL ready_after_release got rdy=%b val=%b exp rdy=1 val=0", byte_ready, blk_valid);
    end
  endtask

  task automatic test_full_ad();
    for (int i = 1; i <= 8; i++) applyStimulus(1'b0, 8'(i), (i == 8), 1'b1);
    idle();
    checks++;
    if (blk_valid !== 1'b1 || blk_data !== 64'h0102030405060708 || blk_len !== 4'd8 ||
        blk_is_ad !== 1'b1 || blk_last !== 1'b0 || byte_ready !== 1'b0) begin
      failures++;
      $display("[TB] FAIL full_ad_block got val=%b data=%h len=%0d ad=%b last=%b rdy=%b exp 1 0102030405060708 8 1 0 0",
               blk_valid, blk_data, blk_len, blk_is_ad, blk_last, byte_ready);
    end
    pulse_read();
    checks++;
    if (blk_valid !== 1'b1 || blk_data !== 64'd0 || blk_len !== 4'd0 ||
        blk_is_ad !== 1'b1 || blk_last !== 1'b1 || byte_ready !== 1'b0) begin
      failures++;
      $display("[TB] FAIL empty_block got val=%b data=%h len=%0d ad=%b last=%b rdy=%b exp 1 0 0 1 1 0",
               blk_valid, blk_data, blk_len, blk_is_ad, blk_last, byte_ready);
    end
    pulse_read();
    checks++;
    if (byte_ready !== 1'b1 || blk_valid !== 1'b0) begin
      failures++;
      $display("[TB] FAIL after_empty_read got rdy=%b val=%b exp rdy=1 val=0", byte_ready, blk_valid);
    end
  endtask

  task automatic test_short_pt();
    applyStimulus(1'b0, 8'hAA, 1'b0, 1'b0);
    applyStimulus(1'b0, 8'hBB, 1'b0, 1'b0);
    checks++;
    if (blk_valid !== 1'b0) begin
      failures++;
      $display("[TB] FAIL short_early_valid got=%b exp=0", blk_valid);
    end
    applyStimulus(1'b0, 8'hCC, 1'b1, 1'b0);
    idle();
    checks++;
    if (blk_valid !== 1'b1 || blk_data !== 64'hAABBCC0000000000 || blk_len !== 4'd3 ||
        blk_is_ad !== 1'b0 || blk_last !== 1'b1) begin
      failures++;
      $display("[TB] FAIL short_block got val=%b data=%h len=%0d ad=%b last=%b exp 1 aabbcc0000000000 3 0 1",
               blk_valid, blk_data, blk_len, blk_is_ad, blk_last);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (byte_ready !== 1'b0 || blk_valid !== 1'b1) begin
      failures++;
      $display("[TB] FAIL short_wait_read got rdy=%b val=%b exp rdy=0 val=1", byte_ready, blk_valid);
    end
    pulse_read();
    checks++;
    if (byte_ready !== 1'b1 || blk_valid !== 1'b0) begin
      failures++;
      $display("[TB] FAIL short_after_read got rdy=%b val=%b exp rdy=1 val=0", byte_ready, blk_valid);
    end
  endtask

  // Sends 11 plaintext bytes with an idle cycle between bytes. The last two
  // bytes carry is_ad=1, and the block type must still come from its first byte.
  task automatic test_toggle_valid();
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b0, 8'h10 + 8'(i), 1'b0, 1'b0);
      idle();
      @(negedge clk);
    end
    checks++;
    if (blk_valid !== 1'b1 || blk_data !== 64'h1011121314151617 || blk_len !== 4'd8 ||
        blk_is_ad !== 1'b0 || blk_last !== 1'b0) begin
      failures++;
      $display("[TB] FAIL toggle_block1 got val=%b data=%h len=%0d ad=%b last=%b exp 1 1011121314151617 8 0 0",
               blk_valid, blk_data, blk_len, blk_is_ad, blk_last);
    end
    pulse_read();
    applyStimulus(1'b0, 8'h18, 1'b0, 1'b0);
    idle();
    @(negedge clk);
    applyStimulus(1'b0, 8'h19, 1'b0, 1'b1);
    idle();
    @(negedge clk);
    applyStimulus(1'b0, 8'h1A, 1'b1, 1'b1);
    idle();
    checks++;
    if (blk_valid !== 1'b1 || blk_data !== 64'h18191A0000000000 || blk_len !== 4'd3 ||
        blk_is_ad !== 1'b0 || blk_last !== 1'b1) begin
      failures++;
      $display("[TB] FAIL toggle_block2 got val=%b data=%h len=%0d ad=%b last=%b exp 1 18191a0000000000 3 0 1",
               blk_valid, blk_data, blk_len, blk_is_ad, blk_last);
    end
    pulse_read();
  endtask

  task automatic test_stall();
    applyStimulus(1'b0, 8'h21, 1'b0, 1'b1);
    applyStimulus(1'b0, 8'h22, 1'b1, 1'b1);
    byte_in = 8'h99;
    byte_last = 1'b1;
    byte_is_ad = 1'b0;
    byte_valid = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      checks++;
      if (blk_valid !== 1'b1 || blk_data !== 64'h2122000000000000 || blk_len !== 4'd2 ||
          blk_is_ad !== 1'b1 || blk_last !== 1'b1 || byte_ready !== 1'b0) begin
        failures++;
        $display("[TB] FAIL stall_hold cycle=%0d got val=%b data=%h len=%0d ad=%b last=%b rdy=%b exp 1 2122000000000000 2 1 1 0",
                 c, blk_valid, blk_data, blk_len, blk_is_ad, blk_last, byte_ready);
      end
    end
    pulse_read();
    applyStimulus(1'b0, 8'h99, 1'b1, 1'b0);
    idle();
    checks++;
    if (blk_valid !== 1'b1 || blk_data !== 64'h9900000000000000 || blk_len !== 4'd1 ||
        blk_is_ad !== 1'b0 || blk_last !== 1'b1) begin
      failures++;
      $display("[TB] FAIL stall_held_byte got val=%b data=%h len=%0d ad=%b last=%b exp 1 9900000000000000 1 0 1",
               blk_valid, blk_data, blk_len, blk_is_ad, blk_last);
    end
    pulse_read();
    pulse_read();
    for (int c = 0; c < 3; c++) begin
      checks++;
      if (blk_valid !== 1'b0 || byte_ready !== 1'b1) begin
        failures++;
        $display("[TB] FAIL read_in_fill cycle=%0d got val=%b rdy=%b exp val=0 rdy=1", c, blk_valid, byte_ready);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 5; i++) applyStimulus(1'b0, 8'hE1 + 8'(i), 1'b0, 1'b1);
    idle();
    rst = 1'b1;
    #1;
    checks++;
    if (byte_ready !== 1'b0 || blk_valid !== 1'b0 || blk_data !== 64'd0 || blk_len !== 4'd0) begin
      failures++;
      $display("[TB] FAIL async_reset got rdy=%b val=%b data=%h len=%0d exp 0 0 0 0",
               byte_ready, blk_valid, blk_data, blk_len);
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      checks++;
      if (blk_valid !== 1'b0 || byte_ready !== 1'b1) begin
        failures++;
        $display("[TB] FAIL post_reset_idle got val=%b rdy=%b exp val=0 rdy=1", blk_valid, byte_ready);
      end
    end
    applyStimulus(1'b0, 8'h55, 1'b1, 1'b0);
    idle();
    checks++;
    if (blk_valid !== 1'b1 || blk_data !== 64'h5500000000000000 || blk_len !== 4'd1 ||
        blk_last !== 1'b1 || blk_is_ad !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_mid_block got val=%b data=%h len=%0d last=%b ad=%b exp 1 5500000000000000 1 1 0",
               blk_valid, blk_data, blk_len, blk_last, blk_is_ad);
    end
    pulse_read();
    // A reset taken in HOLD with an empty block pending must drop that block.
    for (int i = 0; i < 8; i++) applyStimulus(1'b0, 8'hA0 + 8'(i), (i == 7), 1'b1);
    idle();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    applyStimulus(1'b0, 8'h66, 1'b1, 1'b0);
    idle();
    checks++;
    if (blk_valid !== 1'b1 || blk_data !== 64'h6600000000000000 || blk_len !== 4'd1 || blk_last !== 1'b1) begin
      failures++;
      $display("[TB] FAIL reset_in_hold got val=%b data=%h len=%0d last=%b exp 1 6600000000000000 1 1",
               blk_valid, blk_data, blk_len, blk_last);
    end
    pulse_read();
    checks++;
    if (blk_valid !== 1'b0 || byte_ready !== 1'b1) begin
      failures++;
      $display("[TB] FAIL reset_pending_cleared got val=%b rdy=%b exp val=0 rdy=1", blk_valid, byte_ready);
    end
  endtask

  task automatic test_no_flush();
    for (int i = 0; i < 8; i++) applyStimulus(1'b1, 8'hC1 + 8'(i), (i == 7), 1'b0);
    idle();
    checks++;
    if (nf_blk_valid !== 1'b1 || nf_blk_data !== 64'hC1C2C3C4C5C6C7C8 || nf_blk_len !== 4'd8 ||
        nf_blk_last !== 1'b1 || nf_blk_is_ad !== 1'b0) begin
      failures++;
      $display("[TB] FAIL noflush_block got val=%b data=%h len=%0d last=%b ad=%b exp 1 c1c2c3c4c5c6c7c8 8 1 0",
               nf_blk_valid, nf_blk_data, nf_blk_len, nf_blk_last, nf_blk_is_ad);
    end
    nf_read = 1'b1;
    @(negedge clk);
    nf_read = 1'b0;
    for (int c = 0; c < 3; c++) begin
      checks++;
      if (nf_blk_valid !== 1'b0 || nf_byte_ready !== 1'b1) begin
        failures++;
        $display("[TB] FAIL noflush_no_empty cycle=%0d got val=%b rdy=%b exp val=0 rdy=1", c, nf_blk_valid, nf_byte_ready);
      end
      @(negedge clk);
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst = 1'b1;
    byte_in = 8'h00;
    byte_valid = 1'b0;
    byte_last = 1'b0;
    byte_is_ad = 1'b0;
    read = 1'b0;
    nf_byte_valid = 1'b0;
    nf_read = 1'b0;
    test_reset();
    test_full_ad();
    test_short_pt();
    test_toggle_valid();
    test_stall();
    test_reset_mid();
    test_no_flush();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ascon_block_packer.md
ASCON_BLOCK_PACKER -- requirements
Module: ascon_block_packer

Interface
REQ-001 Parameter: FLUSH_EMPTY, default 1, meaning: when 1, a segment whose length is a nonzero multiple of 8 bytes is followed by one extra empty block (len 0, last=1).
REQ-002 clk  input  1  single clock; all state changes on its rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 byte_in  input  8  next byte of the AD or plaintext stream.
REQ-005 byte_valid  input  1  byte_in is valid this cycle.
REQ-006 byte_last  input  1  byte_in is the final byte of the current segment.
REQ-007 byte_is_ad  input  1  1 = associated data, 0 = plaintext.
REQ-008 byte_ready  output  1  packer accepts a byte this cycle.
REQ-009 blk_data  output  64  packed block, first byte in [63:56], unused low bytes zero.
REQ-010 blk_len  output  4  valid bytes in blk_data, 0..8; feeds the core ADlen/PTlen.
REQ-011 blk_is_ad  output  1  block type; feeds the ADblock vs PTblock selection.
REQ-012 blk_last  output  1  block is the final block of its segment.
REQ-013 blk_valid  output  1  block outputs are stable and valid.
REQ-014 read  input  1  core consumed the presented block (single-cycle pulse).

Function
REQ-015 A byte is accepted only in a cycle where byte_valid=1 and byte_ready=1.
REQ-016 FSM states: FILL, HOLD, EMPTY. byte_ready=1 only in FILL; blk_valid=1 only in HOLD and EMPTY.
REQ-017 FILL: a byte counter cnt (3 bits, reset 0) selects the byte lane; an accepted byte writes lane (7-cnt), then cnt increments.
REQ-018 blk_is_ad is latched from byte_is_ad of the first byte of a block (cnt=0); byte_is_ad of later bytes in the same block is ignored.
REQ-019 FILL->HOLD on an accepted byte with cnt=7 or byte_last=1; blk_len = cnt+1 at that byte; cnt returns to 0.
REQ-020 blk_valid rises the cycle after the transition byte is accepted; blk_data, blk_len, blk_is_ad and blk_last are stable while blk_valid=1.
REQ-021 blk_last=1 in HOLD iff byte_last was set on the transition byte and not (FLUSH_EMPTY=1 and blk_len=8).
REQ-022 With FLUSH_EMPTY=1, byte_last on a byte with cnt=7 sets a pending flag; the full block has blk_last=0.
REQ-023 HOLD: read=1 -> EMPTY if the pending flag is set, else FILL; read in FILL is ignored.
REQ-024 EMPTY: blk_data=0, blk_len=0, blk_last=1, blk_is_ad unchanged; read=1 -> FILL and clears the pending flag.
REQ-025 The data register and the lane counter are cleared whenever FILL is entered, so unused lanes are always zero.
REQ-026 byte_ready returns to 1 the cycle after read is sampled in HOLD (no pending flag) or EMPTY; the minimum period for 8 bytes is 9 cycles plus the core's read latency.
REQ-027 byte_valid with byte_ready=0 is not consumed; the source holds its byte.
REQ-028 byte_last with cnt=0 gives blk_len=1; there is no zero-length segment input; empty AD/PT is the caller's concern.

Reset
REQ-029 rst=1 immediately forces: state FILL, cnt=0, pending=0, blk_data=0, blk_len=0, blk_is_ad=0, blk_last=0, blk_valid=0, byte_ready=0.
REQ-030 byte_ready is registered and rises on the first clk edge after rst deasserts.
REQ-031 Reset mid-block or in HOLD/EMPTY discards all partial and pending data; no block is presented after release until new bytes arrive.

Verification
REQ-032 Send bytes 0x01..0x08, is_ad=1, last on 0x08, with FLUSH_EMPTY=1 -> blk_data=0x0102030405060708, len=8, is_ad=1, last=0; after read -> len=0, data=0, last=1; after read -> byte_ready=1.
REQ-033 Send 0xAA,0xBB,0xCC, is_ad=0, last on 0xCC -> blk_data=0xAABBCC0000000000, len=3, is_ad=0, last=1; blk_valid rises 1 cycle after 0xCC; byte_ready stays 0 until read.
REQ-034 Send 11 plaintext bytes 0x10..0x1A with byte_valid toggling every other cycle -> block 1: 0x1011121314151617, len=8, last=0; block 2: 0x18191A0000000000, len=3, last=1.
REQ-035 Hold read low for 20 cycles in HOLD while byte_valid=1 -> outputs remain constant, no byte is accepted; pulse read in FILL -> no effect.
REQ-036 Assert rst after 5 bytes of a block, then release and send 0x55 with last -> blk_data=0x5500000000000000, len=1, last=1; no stale bytes.
REQ-037 With FLUSH_EMPTY=0, send 8 bytes with last -> a single block with len=8, last=1; after read -> FILL, and no empty block is produced.
